// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Ports: clk, rst_n (async, active-low); value_in/value_valid/value_ready
//   load a packed BCD value (nibble i = digit i, digit 0 rightmost);
//   digit_bcd drives the shared decoder, digit_sel is the one-hot active-high
//   digit enable, digit_blank is high while no digit is lit, and frame_done
//   pulses for one cycle after each full frame.
// Optional macro SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN: suppress leading-zero
//   digits (digit 0 is always shown).
module seven_segment_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic [3:0]              digit_bcd,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    digit_blank,
    output logic                    frame_done
);

    localparam int VW   = 4 * NUM_DIGITS;
    localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES
                                                        : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] D_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] B_LAST =
        CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        S_BLANK,
        S_SHOW
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic [VW-1:0]       shadow;
    logic [VW-1:0]       shadow_nxt;
    logic [VW-1:0]       pending;
    logic [VW-1:0]       pending_nxt;
    logic                pend_full;
    logic                pend_full_nxt;
    logic                boundary;
    logic                xfer;
    logic [NUM_DIGITS-1:0] sel_nxt;
    logic [NUM_DIGITS-1:0] supp;
    logic [3:0]          bcd_nxt;

    // Sequencing and the shadow/pending double buffer.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        cnt_nxt       = cnt + 1'b1;
        boundary      = 1'b0;
        shadow_nxt    = shadow;
        pending_nxt   = pending;
        pend_full_nxt = pend_full;
        xfer          = value_valid & value_ready;

        unique case (state)
            S_BLANK: begin
                if (cnt == B_LAST) begin
                    state_nxt = S_SHOW;
                    cnt_nxt   = '0;
                end
            end
            S_SHOW: begin
                if (cnt == D_LAST) begin
                    cnt_nxt  = '0;
                    boundary = (idx == I_LAST);
                    idx_nxt  = (idx == I_LAST) ? '0 : idx + 1'b1;
                    // With no gap configured, SHOW chains to SHOW.
                    if (BLANK_CYCLES > 0)
                        state_nxt = S_BLANK;
                end
            end
        endcase

        // Swap only at the frame edge so a frame never mixes values.
        if (boundary && pend_full) begin
            shadow_nxt    = pending;
            pend_full_nxt = 1'b0;
        end
        // A load on the boundary edge lands in pending, not shadow.
        if (xfer) begin
            pending_nxt   = value_in;
            pend_full_nxt = 1'b1;
        end
    end

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    logic lz_run;

    // Digit i is suppressed when it and every higher nibble are zero.
    always_comb begin
        lz_run = 1'b1;
        supp   = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run  = lz_run & (shadow_nxt[4*i +: 4] == 4'd0);
            supp[i] = lz_run;
        end
    end
`else
    assign supp = '0;
`endif

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        sel_nxt = '0;
        if (state_nxt == S_SHOW)
            sel_nxt[idx_nxt] = 1'b1;
        sel_nxt = sel_nxt & ~supp;
        bcd_nxt = shadow_nxt[idx_nxt*4 +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BLANK;
            idx         <= '0;
            cnt         <= '0;
            shadow      <= '0;
            pending     <= '0;
            pend_full   <= 1'b0;
            value_ready <= 1'b1;
            digit_sel   <= '0;
            digit_bcd   <= '0;
            digit_blank <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            shadow      <= shadow_nxt;
            pending     <= pending_nxt;
            pend_full   <= pend_full_nxt;
            value_ready <= ~pend_full_nxt;
            digit_sel   <= sel_nxt;
            digit_bcd   <= bcd_nxt;
            digit_blank <= ~|sel_nxt;
            frame_done  <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: cycle-indexed display model
// plus directed load/reset scenarios with literal expectations.
module tb_seven_segment_scan_controller;

    localparam int N  = 4;
    localparam int DC = 4;
    localparam int BC = 2;
    localparam int SL = BC + DC;
    localparam int FP = N * SL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   value_in = 16'h0;
    logic          value_valid = 1'b0;
    logic          value_ready;
    logic [3:0]    digit_bcd;
    logic [N-1:0]  digit_sel;
    logic          digit_blank;
    logic          frame_done;

    seven_segment_scan_controller #(
        .NUM_DIGITS  (N),
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .digit_bcd  (digit_bcd),
        .digit_sel  (digit_sel),
        .digit_blank(digit_blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: cycle number since reset, displayed value, one-deep buffer.
    int          mt = 0;
    logic [15:0] m_shadow = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic        m_full = 1'b0;
    logic        m_ready = 1'b1;
    logic        m_xfer;
    logic        m_bnd;

    assign m_xfer = value_valid & m_ready;
    assign m_bnd  = (mt % FP) == FP - 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt       <= 0;
            m_shadow <= 16'h0;
            m_pend   <= 16'h0;
            m_full   <= 1'b0;
            m_ready  <= 1'b1;
        end else begin
            if (m_bnd && m_full)
                m_shadow <= m_pend;
            if (m_xfer)
                m_pend <= value_in;
            m_full  <= m_xfer | (m_full & ~m_bnd);
            m_ready <= ~(m_xfer | (m_full & ~m_bnd));
            mt      <= mt + 1;
        end
    end

    // Every cycle: derive expected outputs from the cycle position.
    always @(negedge clk) begin
        int pos;
        int d;
        logic [3:0] es;
        logic [3:0] eb;
        pos = mt % FP;
        d   = pos / SL;
        es  = 4'b0;
        if ((pos % SL) >= BC)
            es = 4'b1 << d;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
        if (d > 0 && (m_shadow >> (4 * d)) == 16'h0)
            es = 4'b0;
`endif
        eb = m_shadow[4*d +: 4];
        chk("model_sel", 32'(digit_sel), 32'(es));
        chk("model_bcd", 32'(digit_bcd), 32'(eb));
        chk("model_blank", 32'(digit_blank), 32'(es == 4'b0));
        chk("model_frame_done", 32'(frame_done),
            32'(mt > 0 && pos == 0));
        chk("model_ready", 32'(value_ready), 32'(m_ready));
    end

    task automatic wait_mt(input int target);
        int n;
        n = 0;
        while (mt != target && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (mt != target) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_mt: cycle %0d, expected %0d", mt, target);
        end
    endtask

    task automatic load(input int at, input logic [15:0] v);
        wait_mt(at);
        value_in    = v;
        value_valid = 1'b1;
        wait_mt(at + 1);
        value_valid = 1'b0;
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(digit_sel), 32'h0);
        chk("rst_bcd", 32'(digit_bcd), 32'h0);
        chk("rst_blank", 32'(digit_blank), 32'h1);
        chk("rst_ready", 32'(value_ready), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);
        #2 rst_n = 1'b1;

        // 1: idle scan of zeros
        wait_mt(1);  chk("t1_sel1", 32'(digit_sel), 32'h0);
        wait_mt(2);  chk("t1_sel2", 32'(digit_sel), 32'h1);
        wait_mt(5);  chk("t1_sel5", 32'(digit_sel), 32'h1);
        wait_mt(6);  chk("t1_sel6", 32'(digit_sel), 32'h0);
        wait_mt(8);  chk("t1_sel8", 32'(digit_sel), 32'h2);
        wait_mt(14); chk("t1_sel14", 32'(digit_sel), 32'h4);
        wait_mt(20); chk("t1_sel20", 32'(digit_sel), 32'h8);
        wait_mt(23); chk("t1_fd23", 32'(frame_done), 32'h0);
        wait_mt(24); chk("t1_fd24", 32'(frame_done), 32'h1);
        wait_mt(25); chk("t1_fd25", 32'(frame_done), 32'h0);

        // 2: mid-frame load of 1234
        load(30, 16'h1234);
        chk("t2_ready_low", 32'(value_ready), 32'h0);
        wait_mt(32); chk("t2_old_bcd", 32'(digit_bcd), 32'h0);
        wait_mt(47); chk("t2_ready47", 32'(value_ready), 32'h0);
        wait_mt(48);
        chk("t2_ready48", 32'(value_ready), 32'h1);
        chk("t2_fd48", 32'(frame_done), 32'h1);
        wait_mt(50); chk("t2_bcd_d0", 32'(digit_bcd), 32'h4);
        wait_mt(56); chk("t2_bcd_d1", 32'(digit_bcd), 32'h3);
        chk("t2_sel_d1", 32'(digit_sel), 32'h2);
        wait_mt(62); chk("t2_bcd_d2", 32'(digit_bcd), 32'h2);
        wait_mt(68); chk("t2_bcd_d3", 32'(digit_bcd), 32'h1);
        chk("t2_sel_d3", 32'(digit_sel), 32'h8);

        // 3: 5678 held while not ready
        wait_mt(74);
        value_in    = 16'h1234;
        value_valid = 1'b1;
        wait_mt(75);
        value_in = 16'h5678;
        wait_mt(90); chk("t3_ready90", 32'(value_ready), 32'h0);
        n = 0;
        while (!value_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t3_accept_cycle", 32'(mt), 32'd96);
        @(negedge clk);
        value_valid = 1'b0;
        wait_mt(98);  chk("t3_f4_bcd", 32'(digit_bcd), 32'h4);
        wait_mt(122); chk("t3_f5_bcd0", 32'(digit_bcd), 32'h8);
        wait_mt(128); chk("t3_f5_bcd1", 32'(digit_bcd), 32'h7);

        // 6: load on the frame-boundary edge
        load(143, 16'h4321);
        chk("t6_ready144", 32'(value_ready), 32'h0);
        wait_mt(146); chk("t6_bcd_old", 32'(digit_bcd), 32'h8);
        wait_mt(168); chk("t6_ready168", 32'(value_ready), 32'h1);
        wait_mt(170); chk("t6_bcd_new", 32'(digit_bcd), 32'h1);
        chk("t6_sel_new", 32'(digit_sel), 32'h1);

        // 5: non-decimal nibble, leading zeros
        load(170, 16'h00A0);
        wait_mt(194); chk("t5_sel_d0", 32'(digit_sel), 32'h1);
        chk("t5_bcd_d0", 32'(digit_bcd), 32'h0);
        load(194, 16'h0000);
        wait_mt(200); chk("t5_bcd_d1", 32'(digit_bcd), 32'hA);
        chk("t5_sel_d1", 32'(digit_sel), 32'h2);
        wait_mt(206);
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
        chk("t5_sel_d2", 32'(digit_sel), 32'h0);
        chk("t5_blank_d2", 32'(digit_blank), 32'h1);
`else
        chk("t5_sel_d2", 32'(digit_sel), 32'h4);
        chk("t5_blank_d2", 32'(digit_blank), 32'h0);
`endif
        wait_mt(218); chk("t5_zero_sel0", 32'(digit_sel), 32'h1);
        load(218, 16'h1234);
        wait_mt(224);
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
        chk("t5_zero_sel1", 32'(digit_sel), 32'h0);
`else
        chk("t5_zero_sel1", 32'(digit_sel), 32'h2);
`endif

        // 4: reset during SHOW of digit 2
        wait_mt(255);
        chk("t4_pre_sel", 32'(digit_sel), 32'h4);
        chk("t4_pre_bcd", 32'(digit_bcd), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_sel", 32'(digit_sel), 32'h0);
        chk("t4_rst_bcd", 32'(digit_bcd), 32'h0);
        chk("t4_rst_blank", 32'(digit_blank), 32'h1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_mt(1);  chk("t4_post_sel1", 32'(digit_sel), 32'h0);
        wait_mt(2);  chk("t4_post_sel2", 32'(digit_sel), 32'h1);
        chk("t4_post_bcd", 32'(digit_bcd), 32'h0);
        wait_mt(62); chk("t4_post_bcd_d2", 32'(digit_bcd), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
